mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle MIPS control unit. It replaces the single-cycle combinational opcode/func decoder with a clocked state machine that sequences fetch, decode, execute, memory and write-back over several cycles. It handshakes with a single shared instruction/data memory, detects illegal instructions and memory timeouts, and drives every datapath enable and mux select from the current state. It sits between the instruction register and the datapath (PC, register file, ALU, memory port).

## Interface
- `OPW`, 6: opcode width.
- `FNW`, 6: func field width.
- `MEM_TIMEOUT`, 15: maximum cycles `mem_req` may wait for `mem_ack` before trapping. Legal range is 1..255.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `op_code` input OPW: opcode from the instruction register.
- `func` input FNW: func field from the instruction register.
- `zero` input 1: ALU zero flag.
- `mem_ack` input 1: memory transfer complete.
- `mem_req`, `mem_we`, `iord` output 1 each: memory request, memory write, and address select (0 = PC, 1 = ALUOut).
- `ir_we`, `pc_we`, `reg_we` output 1 each: write enables for the instruction register, PC and register file.
- `reg_dst` output 1: register destination select (1 = rd, 0 = rt).
- `mem_to_reg` output 1: write-back source select (1 = memory data).
- `alu_src_a` output 1: ALU A select (0 = PC, 1 = rs).
- `alu_src_b` output 2: ALU B select (00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2).
- `alu_op` output 3: ALU operation (ADD 000, SUB 001, AND 010, OR 011, SLT 100).
- `pc_src` output 2: PC source select (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `trap` output 1: sticky trap flag.
- `trap_cause` output 2: trap reason (00 none, 01 illegal instruction, 10 memory timeout).
- `instr_cnt`, `cycle_cnt` output 32 each: performance counters (see Configuration).

## Operation
- Supported R-type instructions (opcode 000000):
  - add: func 100000.
  - sub: func 100010.
  - and: func 100100.
  - or: func 100101.
  - slt: func 101010.
  - nop: func 000000.
- Supported I/J-type opcodes: lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Any other encoding is illegal.
- States are FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP and TRAP.
- Outputs are Moore: they are decoded from the current state plus the opcode/func registers latched in DECODE. Any output not listed for a state is 0.
- FETCH:
  - Drives `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_src`=00.
  - `ir_we` and `pc_we` are asserted only in the cycle `mem_ack`=1; the state then moves to DECODE.
- DECODE:
  - Latches `op_code` and `func`.
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=ADD (branch target).
  - Next state: nop → FETCH; illegal → TRAP; beq → BRANCH; j → JUMP; all others → EXEC.
- EXEC:
  - Drives `alu_src_a`=1.
  - R-type: `alu_src_b`=00 and `alu_op` from func.
  - addi, lw, sw: `alu_src_b`=10 and `alu_op`=ADD.
  - Next state: lw/sw → MEM; otherwise → WB.
- MEM:
  - Drives `mem_req`=1, `iord`=1, and `mem_we`=1 for sw.
  - On `mem_ack`: sw → FETCH, lw → WB.
- WB:
  - Drives `reg_we`=1, `reg_dst`=1 for R-type, and `mem_to_reg`=1 for lw.
  - Next state is FETCH.
- BRANCH:
  - Drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=SUB, `pc_src`=01.
  - `pc_we`=`zero`.
  - Next state is FETCH.
- JUMP: drives `pc_we`=1 and `pc_src`=10; next state is FETCH.
- TRAP: `trap`=1 and every enable is 0. The only exit is `rst`.
- Memory handshake:
  - `mem_req`, `iord` and `mem_we` stay stable until the cycle `mem_ack` is sampled high.
  - `mem_ack` is ignored in any state that does not request memory.
  - A wait counter increments each cycle `mem_req`=1 and `mem_ack`=0, and clears on ack or state change.
  - When the counter reaches `MEM_TIMEOUT`, the state goes to TRAP with cause 10.
  - If `mem_ack` arrives in that same cycle, the ack wins.

## Timing
- Reset state is FETCH with the wait counter at 0, `trap_cause` at 00, and the performance counters at 0.
- During reset all outputs are at their FETCH values: `mem_req`=1, `alu_src_b`=01, everything else 0.
- Asserting `rst` mid-transfer returns to FETCH immediately. Any in-flight memory ack is discarded.
- Cycle counts with zero-wait memory (`mem_ack` in the first FETCH/MEM cycle):
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
  - nop: 2 cycles.
- Each memory wait cycle adds 1 cycle.
- `trap_cause` is written once on TRAP entry and then holds.

## Configuration
- `MIPS_MC_CTRL_PERF_EN` defined:
  - `cycle_cnt` increments every non-reset cycle.
  - `instr_cnt` increments on each transition back to FETCH from WB, MEM (sw), BRANCH, JUMP or DECODE (nop).
  - Both counters wrap modulo 2^32 and freeze in TRAP.
- Undefined: both ports exist and are tied to 0, and no counter flops are inferred.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the state enum;
  - opcode and func localparams;
  - the `alu_op`, `alu_src_b`, `pc_src` and `trap_cause` encodings.
- One sub-module, `mips_alu_dec`: purely combinational, maps the latched func to `alu_op`. It is also reused by future pipelined control.

## Test plan
- add (op 000000, func 100000), zero-wait memory → FETCH, DECODE, EXEC, WB in 4 cycles; WB has `reg_we`=1, `reg_dst`=1, `alu_op`=000 in EXEC; `instr_cnt`=1 when enabled.
- lw (op 100011), `mem_ack` delayed 3 cycles in MEM → `mem_req` and `iord`=1 held for 4 cycles; WB has `mem_to_reg`=1; 8 cycles total.
- beq (op 000100) with `zero`=1, then with `zero`=0 → BRANCH gives `pc_we`=1 with `pc_src`=01, then `pc_we`=0; 3 cycles each.
- op 111111 → TRAP after DECODE with `trap_cause`=01, all enables 0, held for 20 cycles until `rst`.
- `mem_ack` never asserted in FETCH with `MEM_TIMEOUT`=15 → TRAP with `trap_cause`=10 on the 16th cycle.
- `rst` asserted mid-MEM of sw → `mem_we` drops asynchronously and the FSM restarts in FETCH; a later ack is ignored.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control unit and its
//   helpers: the FSM state enum, the opcode and func encodings, and the
//   encodings of the alu_op, alu_src_b, pc_src and trap_cause outputs.
//   No ports; imported with "import mips_ctrl_pkg::*;".
package mips_ctrl_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  // Opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type func codes.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOP = 6'b000000;

  // ALU operations.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // ALU B operand select.
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select.
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Trap causes.
  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

  // True when the opcode/func pair is one the controller implements.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOP: ok = 1'b1;
          default:                                       ok = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if
//   Shared instruction/data memory handshake between the control unit
//   (master) and the memory port (slave).
//   Signals:
//     mem_req  master->slave  transfer request
//     mem_we   master->slave  1 = write, 0 = read
//     iord     master->slave  address select (0 = PC, 1 = ALUOut)
//     mem_ack  slave->master  transfer complete
//   Handshake: mem_req acts as valid and mem_ack as ready. Once mem_req is
//   raised, mem_req, mem_we and iord hold steady until the rising edge on
//   which mem_ack is sampled high; that edge completes the transfer. The
//   master ignores mem_ack whenever mem_req is low.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output iord, input mem_ack);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/mips_alu_dec.sv
// mips_alu_dec
//   Purely combinational R-type func -> ALU operation decoder. Shared by the
//   multi-cycle controller and later pipelined control.
//   Ports:
//     func    in  FNW  func field (latched copy in the multi-cycle unit)
//     alu_op  out 3    ALU operation; ADD for any func it does not map
module mips_alu_dec
  import mips_ctrl_pkg::*;
#(
  parameter int FNW = 6
) (
  input  logic [FNW-1:0] func,
  output logic [2:0]     alu_op
);

  logic [5:0] fn6;
  assign fn6 = 6'(func);

  always_comb begin
    alu_op = ALU_ADD;
    case (fn6)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multi-cycle MIPS control unit. A Moore FSM steps each instruction through
//   FETCH, DECODE, EXEC, MEM, WB, BRANCH or JUMP and drives every datapath
//   enable and mux select from the current state plus the opcode/func
//   latched in DECODE. Illegal instructions and memory waits longer than
//   MEM_TIMEOUT cycles park the FSM in TRAP until rst.
//   Optional build macro: MIPS_MC_CTRL_PERF_EN enables the instr_cnt and
//   cycle_cnt performance counters; without it both ports read 0.
//   Ports:
//     clk, rst         clock; asynchronous active-high reset
//     mem              memory handshake (master modport)
//     op_code, func    instruction register fields
//     zero             ALU zero flag
//     ir_we, pc_we, reg_we               write enables
//     reg_dst, mem_to_reg, alu_src_a     datapath selects
//     alu_src_b, alu_op, pc_src          datapath selects
//     trap, trap_cause                   sticky trap flag and reason
//     instr_cnt, cycle_cnt               performance counters
//     state                              current FSM state (debug)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int FNW         = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_multicycle_ctrl_if.master mem,
  input  logic [OPW-1:0]        op_code,
  input  logic [FNW-1:0]        func,
  input  logic                  zero,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  reg_we,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            alu_op,
  output logic [1:0]            pc_src,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [31:0]           instr_cnt,
  output logic [31:0]           cycle_cnt,
  output state_t                state
);

  // The wait counter never exceeds MEM_TIMEOUT-1: the cycle it would reach
  // MEM_TIMEOUT is the cycle the FSM leaves for TRAP.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic [FNW-1:0] fn_q;
  logic [7:0]     wait_q, wait_d;
  logic [1:0]     cause_q;

  logic           mem_req_c, mem_we_c, iord_c;
  logic [2:0]     rtype_alu_op;

  // Fixed-width views of the live and latched instruction fields.
  logic [5:0] op_in6, fn_in6, op6, fn6;
  assign op_in6 = 6'(op_code);
  assign fn_in6 = 6'(func);
  assign op6    = 6'(op_q);
  assign fn6    = 6'(fn_q);

  logic is_rtype, is_lw, is_sw;
  assign is_rtype = (op6 == OP_RTYPE);
  assign is_lw    = (op6 == OP_LW);
  assign is_sw    = (op6 == OP_SW);

  logic timeout_hit;
  assign timeout_hit = (wait_q == WAIT_LAST);

  mips_alu_dec #(.FNW(FNW)) u_alu_dec (
    .func   (fn_q),
    .alu_op (rtype_alu_op)
  );

  // State, latched instruction fields, wait counter and trap cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      wait_q  <= '0;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) begin
        op_q <= op_code;
        fn_q <= func;
      end
      // Cause is captured only on the entry edge and then holds.
      if (state_q != S_TRAP && state_d == S_TRAP) begin
        cause_q <= (state_q == S_DECODE) ? TC_ILLEGAL : TC_TIMEOUT;
      end
    end
  end

  // Next state. DECODE looks at the live IR fields because the latched
  // copies only become valid on the edge that leaves DECODE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem.mem_ack)      state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_DECODE: begin
        if (!is_legal(op_in6, fn_in6))                      state_d = S_TRAP;
        else if (op_in6 == OP_RTYPE && fn_in6 == FN_NOP)    state_d = S_FETCH;
        else if (op_in6 == OP_BEQ)                          state_d = S_BRANCH;
        else if (op_in6 == OP_J)                            state_d = S_JUMP;
        else                                                state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw) state_d = S_MEM;
        else                state_d = S_WB;
      end
      S_MEM: begin
        // An ack in the timeout cycle still completes the transfer.
        if (mem.mem_ack)      state_d = is_sw ? S_FETCH : S_WB;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Count stalled request cycles; any ack or state change restarts it.
  always_comb begin
    wait_d = '0;
    if (mem_req_c && !mem.mem_ack && state_d == state_q) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // Moore outputs from the current state and latched opcode/func.
  always_comb begin
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    iord_c     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    trap       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = SRCB_FOUR;
        // An ack seen while rst is high belongs to an abandoned transfer.
        ir_we     = mem.mem_ack & ~rst;
        pc_we     = mem.mem_ack & ~rst;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (is_rtype) begin
          alu_src_b = SRCB_RT;
          alu_op    = rtype_alu_op;
        end else begin
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_we_c  = is_sw;
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_lw;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we     = zero;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = PC_JUMP;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        trap = 1'b0;
      end
    endcase
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign mem.iord    = iord_c;
  assign trap_cause  = cause_q;
  assign state       = state_q;

`ifdef MIPS_MC_CTRL_PERF_EN
  logic [31:0] instr_q, cycle_q;

  // Both counters freeze once the unit traps. An instruction retires on any
  // return to FETCH; reset is the only other way into FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else if (state_q != S_TRAP) begin
      cycle_q <= cycle_q + 32'd1;
      if (state_d == S_FETCH && state_q != S_FETCH) begin
        instr_q <= instr_q + 32'd1;
      end
    end
  end

  assign instr_cnt = instr_q;
  assign cycle_cnt = cycle_q;
`else
  assign instr_cnt = '0;
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Self-checking bench for mips_multicycle_ctrl. Each instruction is
//   expanded into a per-cycle plan: stimulus words go to stim_q and the
//   expected observable outputs for that cycle go to exp_q. The executor
//   drives one stimulus word per cycle and compares the DUT against the
//   popped expectation at the falling edge.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  op_code;
  logic [5:0]  func;
  logic        zero;
  logic        ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a, trap;
  logic [1:0]  alu_src_b, pc_src, trap_cause;
  logic [2:0]  alu_op;
  logic [31:0] instr_cnt, cycle_cnt;
  state_t      state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if mem_if ();

  mips_multicycle_ctrl #(
    .OPW(6), .FNW(6), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mem_if),
    .op_code    (op_code),
    .func       (func),
    .zero       (zero),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instr_cnt  (instr_cnt),
    .cycle_cnt  (cycle_cnt),
    .state      (state)
  );

  typedef struct packed {
    state_t     st;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       trap;
    logic [1:0] trap_cause;
  } obs_t;
  localparam int W = $bits(obs_t);

  typedef struct packed {
    logic       ack;
    logic       zero;
    logic [5:0] op;
    logic [5:0] fn;
  } stim_t;

  typedef enum logic [2:0] {P_R, P_ADDI, P_LW, P_SW, P_BEQ, P_J, P_NOP} path_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fwait;
    int         mwait;
    path_t      path;
    logic [2:0] exec_alu;
  } vec_t;

  logic [W-1:0] exp_q[$];
  stim_t        stim_q[$];
  vec_t         vecs[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc   = 0;

  // ---------------- helpers ----------------
  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rfield();
    return 6'($urandom_range(0, 63));
  endfunction

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic obs_t mk(state_t st, path_t p, logic [2:0] ex_alu,
                              logic ack, logic z, logic [1:0] cause);
    obs_t o;
    o    = '0;
    o.st = st;
    case (st)
      S_FETCH: begin
        o.mem_req = 1'b1; o.alu_src_b = 2'b01; o.ir_we = ack; o.pc_we = ack;
      end
      S_DECODE: o.alu_src_b = 2'b11;
      S_EXEC: begin
        o.alu_src_a = 1'b1;
        if (p == P_R) begin o.alu_src_b = 2'b00; o.alu_op = ex_alu; end
        else          begin o.alu_src_b = 2'b10; o.alu_op = 3'b000; end
      end
      S_MEM: begin
        o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (p == P_SW);
      end
      S_WB: begin
        o.reg_we = 1'b1; o.reg_dst = (p == P_R); o.mem_to_reg = (p == P_LW);
      end
      S_BRANCH: begin
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_op = 3'b001;
        o.pc_src = 2'b01; o.pc_we = z;
      end
      S_JUMP: begin o.pc_we = 1'b1; o.pc_src = 2'b10; end
      S_TRAP: begin o.trap = 1'b1; o.trap_cause = cause; end
      default: o.st = st;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state;         o.mem_req = mem_if.mem_req; o.mem_we = mem_if.mem_we;
    o.iord = mem_if.iord; o.ir_we = ir_we;            o.pc_we = pc_we;
    o.reg_we = reg_we;    o.reg_dst = reg_dst;        o.mem_to_reg = mem_to_reg;
    o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b; o.alu_op = alu_op;
    o.pc_src = pc_src;    o.trap = trap;              o.trap_cause = trap_cause;
    return o;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_cnt(string name, int exp_instr, int exp_cyc);
`ifdef MIPS_MC_CTRL_PERF_EN
    check({name, "_instr_cnt"}, instr_cnt, 32'(exp_instr));
    check({name, "_cycle_cnt"}, cycle_cnt, 32'(exp_cyc));
`else
    check({name, "_instr_cnt"}, instr_cnt, 32'd0);
    check({name, "_cycle_cnt"}, cycle_cnt, 32'd0);
`endif
  endtask

  // Push one planned cycle. Non-memory states get a random ack, which the
  // DUT must ignore; only DECODE carries the real instruction fields.
  task automatic push(state_t st, path_t p, logic [2:0] ex_alu, logic ack,
                      logic z, logic [5:0] op, logic [5:0] fn, logic [1:0] cause);
    stim_t s;
    s.ack = ack; s.zero = z; s.op = op; s.fn = fn;
    stim_q.push_back(s);
    exp_q.push_back(W'(mk(st, p, ex_alu, ack, z, cause)));
  endtask

  task automatic push_plain(state_t st, path_t p, logic [2:0] ex_alu);
    push(st, p, ex_alu, rbit(), rbit(), rfield(), rfield(), 2'b00);
  endtask

  task automatic plan_instr(vec_t v);
    for (int i = 0; i < v.fwait; i++) push(S_FETCH, v.path, 3'b0, 1'b0, rbit(), rfield(), rfield(), 2'b00);
    push(S_FETCH, v.path, 3'b0, 1'b1, rbit(), rfield(), rfield(), 2'b00);
    push(S_DECODE, v.path, 3'b0, rbit(), rbit(), v.op, v.fn, 2'b00);
    case (v.path)
      P_R, P_ADDI: begin
        push_plain(S_EXEC, v.path, v.exec_alu);
        push_plain(S_WB, v.path, v.exec_alu);
      end
      P_LW, P_SW: begin
        push_plain(S_EXEC, v.path, v.exec_alu);
        for (int i = 0; i < v.mwait; i++) push(S_MEM, v.path, 3'b0, 1'b0, rbit(), rfield(), rfield(), 2'b00);
        push(S_MEM, v.path, 3'b0, 1'b1, rbit(), rfield(), rfield(), 2'b00);
        if (v.path == P_LW) push_plain(S_WB, v.path, v.exec_alu);
      end
      P_BEQ: push(S_BRANCH, v.path, 3'b0, rbit(), v.z, rfield(), rfield(), 2'b00);
      P_J:   push_plain(S_JUMP, v.path, 3'b0);
      default: ;
    endcase
  endtask

  // Executor: drive after the rising edge, compare at the falling edge.
  task automatic run_plan(string tag);
    int step;
    step = 0;
    while (stim_q.size() > 0) begin
      stim_t        s;
      obs_t         got;
      logic [W-1:0] e;
      s = stim_q.pop_front();
      mem_if.mem_ack = s.ack; zero = s.zero; op_code = s.op; func = s.fn;
      @(negedge clk);
      got = sample();
      e   = exp_q.pop_front();
      n_cmp++;
      if (W'(got) !== e) begin
        n_bad++;
        $display("FAIL %s step %0d: actual %h (state %0d) required %h (state %0d)",
                 tag, step, W'(got), got.st, e, e[W-1 -: 3]);
      end
      @(posedge clk); #1;
      cyc++;
      step++;
    end
  endtask

  // Assert reset with an ack pending; outputs must sit at FETCH values with
  // the ack discarded.
  task automatic do_reset();
    rst = 1'b1; mem_if.mem_ack = 1'b1; zero = rbit(); op_code = rfield(); func = rfield();
    #2;
    n_cmp++;
    if (W'(sample()) !== W'(mk(S_FETCH, P_NOP, 3'b0, 1'b0, 1'b0, 2'b00))) begin
      n_bad++;
      $display("FAIL reset_outputs: actual %h required %h", W'(sample()),
               W'(mk(S_FETCH, P_NOP, 3'b0, 1'b0, 1'b0, 2'b00)));
    end
    check("reset_instr_cnt", instr_cnt, 32'd0);
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_if.mem_ack = 1'b0;
    cyc = 0;
  endtask

  task automatic add_vec(string name, logic [5:0] op, logic [5:0] fn, logic z,
                         int fwait, int mwait, path_t path, logic [2:0] exec_alu);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.z = z; v.fwait = fwait;
    v.mwait = mwait; v.path = path; v.exec_alu = exec_alu;
    vecs.push_back(v);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    mem_if.mem_ack = 1'b0; zero = 1'b0; op_code = '0; func = '0;

    add_vec("add",        6'b000000, 6'b100000, 1'b0, 0,  0,  P_R,    3'b000);
    add_vec("sub_fwait2", 6'b000000, 6'b100010, 1'b0, 2,  0,  P_R,    3'b001);
    add_vec("and",        6'b000000, 6'b100100, 1'b0, 0,  0,  P_R,    3'b010);
    add_vec("or",         6'b000000, 6'b100101, 1'b0, 0,  0,  P_R,    3'b011);
    add_vec("slt_fwait1", 6'b000000, 6'b101010, 1'b0, 1,  0,  P_R,    3'b100);
    add_vec("addi",       6'b001000, 6'b110011, 1'b0, 0,  0,  P_ADDI, 3'b000);
    add_vec("lw",         6'b100011, 6'b000111, 1'b0, 0,  0,  P_LW,   3'b000);
    add_vec("lw_mwait3",  6'b100011, 6'b010101, 1'b0, 0,  3,  P_LW,   3'b000);
    add_vec("sw_mwait1",  6'b101011, 6'b000000, 1'b0, 0,  1,  P_SW,   3'b000);
    add_vec("beq_taken",  6'b000100, 6'b111000, 1'b1, 0,  0,  P_BEQ,  3'b000);
    add_vec("beq_not",    6'b000100, 6'b000011, 1'b0, 0,  0,  P_BEQ,  3'b000);
    add_vec("j",          6'b000010, 6'b101010, 1'b0, 0,  0,  P_J,    3'b000);
    add_vec("nop",        6'b000000, 6'b000000, 1'b0, 0,  0,  P_NOP,  3'b000);
    add_vec("add_ack_at_timeout", 6'b000000, 6'b100000, 1'b0, MEM_TIMEOUT-1, 0, P_R, 3'b000);
    add_vec("lw_ack_at_timeout",  6'b100011, 6'b000001, 1'b0, 0, MEM_TIMEOUT-1, P_LW, 3'b000);

    // Table of legal instructions back to back.
    do_reset();
    foreach (vecs[i]) begin
      plan_instr(vecs[i]);
      run_plan(vecs[i].name);
    end
    check_cnt("after_table", vecs.size(), cyc);

    // Illegal opcode: TRAP after DECODE, held for 20 cycles whatever ack does.
    do_reset();
    push(S_FETCH, P_NOP, 3'b0, 1'b1, 1'b0, rfield(), rfield(), 2'b00);
    push(S_DECODE, P_NOP, 3'b0, 1'b0, 1'b0, 6'b111111, rfield(), 2'b00);
    for (int i = 0; i < 20; i++) push(S_TRAP, P_NOP, 3'b0, rbit(), rbit(), rfield(), rfield(), 2'b01);
    run_plan("illegal_op");
    check_cnt("illegal_op", 0, 2);

    // Illegal R-type func.
    do_reset();
    push(S_FETCH, P_NOP, 3'b0, 1'b1, 1'b0, rfield(), rfield(), 2'b00);
    push(S_DECODE, P_NOP, 3'b0, 1'b0, 1'b0, 6'b000000, 6'b100001, 2'b00);
    for (int i = 0; i < 3; i++) push(S_TRAP, P_NOP, 3'b0, rbit(), rbit(), rfield(), rfield(), 2'b01);
    run_plan("illegal_func");

    // Fetch never acknowledged: TRAP with timeout cause in cycle 16.
    do_reset();
    for (int i = 0; i < MEM_TIMEOUT; i++) push(S_FETCH, P_NOP, 3'b0, 1'b0, rbit(), rfield(), rfield(), 2'b00);
    for (int i = 0; i < 5; i++) push(S_TRAP, P_NOP, 3'b0, rbit(), rbit(), rfield(), rfield(), 2'b10);
    run_plan("fetch_timeout");
    check_cnt("fetch_timeout", 0, MEM_TIMEOUT);

    // Load data phase never acknowledged.
    do_reset();
    push(S_FETCH, P_LW, 3'b0, 1'b1, 1'b0, rfield(), rfield(), 2'b00);
    push(S_DECODE, P_LW, 3'b0, 1'b0, 1'b0, 6'b100011, rfield(), 2'b00);
    push_plain(S_EXEC, P_LW, 3'b0);
    for (int i = 0; i < MEM_TIMEOUT; i++) push(S_MEM, P_LW, 3'b0, 1'b0, rbit(), rfield(), rfield(), 2'b00);
    for (int i = 0; i < 3; i++) push(S_TRAP, P_LW, 3'b0, rbit(), rbit(), rfield(), rfield(), 2'b10);
    run_plan("mem_timeout");
    check_cnt("mem_timeout", 0, MEM_TIMEOUT + 3);

    // Reset in the middle of a store's data phase.
    do_reset();
    push(S_FETCH, P_SW, 3'b0, 1'b1, 1'b0, rfield(), rfield(), 2'b00);
    push(S_DECODE, P_SW, 3'b0, 1'b0, 1'b0, 6'b101011, rfield(), 2'b00);
    push_plain(S_EXEC, P_SW, 3'b0);
    push(S_MEM, P_SW, 3'b0, 1'b0, 1'b0, rfield(), rfield(), 2'b00);
    push(S_MEM, P_SW, 3'b0, 1'b0, 1'b0, rfield(), rfield(), 2'b00);
    run_plan("sw_before_rst");
    check("sw_mem_we_before_rst", 32'(mem_if.mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_mem_we",    32'(mem_if.mem_we),  32'd0);
    check("rst_mid_mem_iord",  32'(mem_if.iord),    32'd0);
    check("rst_mid_mem_req",   32'(mem_if.mem_req), 32'd1);
    check("rst_mid_mem_state", 32'(state),          32'(S_FETCH));
    mem_if.mem_ack = 1'b1;
    @(negedge clk);
    check("rst_ack_ignored_ir_we", 32'(ir_we), 32'd0);
    check("rst_ack_ignored_pc_we", 32'(pc_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_if.mem_ack = 1'b0;
    @(negedge clk);
    check("after_rst_state", 32'(state), 32'(S_FETCH));
    check("after_rst_ir_we", 32'(ir_we), 32'd0);
    @(posedge clk); #1;
    plan_instr(vecs[0]);
    run_plan("add_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
